branch_outcome_predictor: RTL and testbench
===========================================

// Module: branch_outcome_predictor
// PURPOSE
//  Predicts beq/bne outcome at fetch; trained by resolved outcome from branch compare in EX.
//  Table of 2-bit saturating counters indexed by PC; 1-cycle registered prediction.
//  Flags mispredicts toward PC redirect logic; keeps branch/miss perf counters.
// PARAMETERS
//  IDX_W    6   index bits; table depth = 2**IDX_W entries
//  ADDR_W   32  PC width
//  CNT_W    32  perf counter width
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  lk_valid      in   1       fetch lookup request
//  lk_pc         in   ADDR_W  fetch PC
//  pred_valid    out  1       registered: lk_valid delayed 1 cycle
//  pred_taken    out  1       registered prediction for lk_pc of previous cycle
//  upd_valid     in   1       resolved branch present (EX)
//  upd_pc        in   ADDR_W  PC of resolved branch
//  upd_taken     in   1       actual outcome from branch compare
//  upd_pred      in   1       prediction carried down pipe with that branch
//  mispredict    out  1       registered 1-cycle pulse: upd_taken != upd_pred
//  stat_clr      in   1       synchronous clear of perf counters
//  branch_cnt    out  CNT_W   resolved branches counted
//  miss_cnt      out  CNT_W   mispredicts counted
// BEHAVIOUR
//  Reset (rst_n=0, async): every table entry = 2'b01 (weakly not-taken);
//   pred_valid=0, pred_taken=0, mispredict=0, branch_cnt=0, miss_cnt=0.
//  Index = pc[IDX_W+1:2]; pc[1:0] ignored (word-aligned).
//  Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST; predict taken = ctr[1].
//  Lookup: cycle N lk_valid=1 -> cycle N+1 pred_valid=1, pred_taken = ctr[idx].
//   lk_valid=0 -> pred_valid=0 next cycle; pred_taken holds last value.
//  Update: on edge where upd_valid=1: ctr[idx] = upd_taken ? min(ctr+1,3) : max(ctr-1,0).
//   Saturation: 11+taken stays 11; 00+not-taken stays 00.
//  Same-cycle collision (lk_valid & upd_valid & equal index): prediction uses
//   post-update counter value (write-before-read forwarding).
//  upd_valid=1 but lk_valid=0: table trains, pred_valid=0.
//  mispredict: cycle N upd_valid & (upd_taken^upd_pred) -> 1 in N+1 only; else 0.
//  Perf counters: upd_valid -> branch_cnt+1; mispredict condition -> miss_cnt+1;
//   wrap modulo 2**CNT_W. stat_clr has priority over increment (result 0 that edge).
//  Reset mid-operation: everything returns to reset values immediately; in-flight
//   lookups/updates dropped; no partial table writes.
//  Single write port, single read port; no stall/ready: both sides always accepted.
// STRUCTURE
//  Shared package: counter encodings SNT/WNT/WT/ST, index-extract function,
//   saturating inc/dec function (reused by future BTB).
//  One sub-module: sat_counter2 (2-bit saturating next-state, combinational) used
//   for table update and forwarding path. Table = register array (async reset needed).
// TESTING
//  1 Reset then lk_pc=0x0000_0040 -> next cycle pred_valid=1, pred_taken=0.
//  2 Two updates pc=0x40 taken -> ctr 01->10->11; lookup 0x40 -> pred_taken=1;
//    a third taken update keeps 11 (saturation).
//  3 Aliasing: pc 0x40 and 0x140 (IDX_W=6) share entry; train 0x40 taken twice,
//    lookup 0x140 -> pred_taken=1.
//  4 Collision: ctr[0x40]=01, same cycle upd taken + lookup 0x40 -> pred_taken=1.
//  5 upd_taken=1, upd_pred=0 -> mispredict=1 one cycle, miss_cnt=1, branch_cnt=1;
//    matching pred -> mispredict=0, branch_cnt=2; stat_clr with upd_valid -> both 0.
//  6 Assert rst_n low mid-stream after training -> outputs 0 asynchronously;
//    after release lookup 0x40 -> pred_taken=0 (entry back to 01).

Source files
------------

// File: rtl/branch_outcome_predictor_pkg.sv
// Shared types and helpers for the branch predictor and future BTB:
// 2-bit counter encodings, PC-to-index extraction and saturating step.
package branch_outcome_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   localparam int PC_W = 32;

   // Word address of a PC; callers keep only as many low bits as their table needs.
   function automatic logic [PC_W-3:0] pcWordIndex(input logic [PC_W-1:0] pc);
      return pc[PC_W-1:2];
   endfunction

   function automatic logic [1:0] satNext(input logic [1:0] ctr, input logic taken);
      logic [1:0] result;
      result = ctr;
      if (taken) begin
         if (ctr != ST) result = ctr + 2'd1;
      end else begin
         if (ctr != SNT) result = ctr - 2'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/branch_outcome_predictor_sat_counter2.sv
// Combinational next state of a 2-bit saturating counter.
module sat_counter2
   import branch_outcome_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] next_o
);

   always_comb begin
      next_o = satNext(ctr_i, taken_i);
   end

endmodule

// File: rtl/branch_outcome_predictor.sv
// PC-indexed table of 2-bit saturating counters with a registered prediction,
// registered mispredict pulse and branch/miss performance counters.
module branch_outcome_predictor
   import branch_outcome_predictor_pkg::*;
#(
   parameter int IDX_W  = 6,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lk_valid,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic              upd_pred,
   output logic              mispredict,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [1:0]       table_q [DEPTH];
   logic [IDX_W-1:0] lkIdx;
   logic [IDX_W-1:0] updIdx;
   logic [1:0]       updCtr;
   logic [1:0]       updNext;
   logic [1:0]       readCtr;
   logic             missNow;

   logic             predValid_q, predValid_d;
   logic             predTaken_q, predTaken_d;
   logic             mispredict_q, mispredict_d;
   logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
   logic [CNT_W-1:0] missCnt_q, missCnt_d;

   assign lkIdx  = IDX_W'(pcWordIndex(PC_W'(lk_pc)));
   assign updIdx = IDX_W'(pcWordIndex(PC_W'(upd_pc)));
   assign updCtr = table_q[updIdx];

   // One counter step serves both the table write and the same-index read bypass.
   sat_counter2 u_sat_counter2 (
      .ctr_i   (updCtr),
      .taken_i (upd_taken),
      .next_o  (updNext)
   );

   always_comb begin
      readCtr      = table_q[lkIdx];
      if (upd_valid && (updIdx == lkIdx)) readCtr = updNext;
      missNow      = upd_valid & (upd_taken ^ upd_pred);
      predValid_d  = lk_valid;
      predTaken_d  = lk_valid ? readCtr[1] : predTaken_q;
      mispredict_d = missNow;
      branchCnt_d  = branchCnt_q;
      missCnt_d    = missCnt_q;
      if (stat_clr) begin
         branchCnt_d = '0;
         missCnt_d   = '0;
      end else begin
         if (upd_valid) branchCnt_d = branchCnt_q + CNT_W'(1);
         if (missNow)   missCnt_d   = missCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= WNT;
      end else if (upd_valid) begin
         table_q[updIdx] <= updNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         predValid_q  <= 1'b0;
         predTaken_q  <= 1'b0;
         mispredict_q <= 1'b0;
         branchCnt_q  <= '0;
         missCnt_q    <= '0;
      end else begin
         predValid_q  <= predValid_d;
         predTaken_q  <= predTaken_d;
         mispredict_q <= mispredict_d;
         branchCnt_q  <= branchCnt_d;
         missCnt_q    <= missCnt_d;
      end
   end

   assign pred_valid = predValid_q;
   assign pred_taken = predTaken_q;
   assign mispredict = mispredict_q;
   assign branch_cnt = branchCnt_q;
   assign miss_cnt   = missCnt_q;

endmodule

// File: tb/tb_branch_outcome_predictor.sv
// Directed self-checking bench for branch_outcome_predictor with hand-computed expectations.
module tb_branch_outcome_predictor;

   logic        clk;
   logic        rst_n;
   logic        lk_valid;
   logic [31:0] lk_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        upd_pred;
   logic        mispredict;
   logic        stat_clr;
   logic [31:0] branch_cnt;
   logic [31:0] miss_cnt;

   int checkCount;
   int passCount;

   branch_outcome_predictor #(
      .IDX_W  (6),
      .ADDR_W (32),
      .CNT_W  (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_valid   (lk_valid),
      .lk_pc      (lk_pc),
      .pred_valid (pred_valid),
      .pred_taken (pred_taken),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_pred   (upd_pred),
      .mispredict (mispredict),
      .stat_clr   (stat_clr),
      .branch_cnt (branch_cnt),
      .miss_cnt   (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge, then return just after the rising edge.
   task automatic applyStimulus(input logic lkV, input logic [31:0] lkPc,
                                input logic updV, input logic [31:0] updPc,
                                input logic updT, input logic updP, input logic clr);
      @(negedge clk);
      lk_valid  = lkV;
      lk_pc     = lkPc;
      upd_valid = updV;
      upd_pc    = updPc;
      upd_taken = updT;
      upd_pred  = updP;
      stat_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " pred_valid"}, {31'b0, pred_valid}, 32'd0);
      checkOutput({tag, " pred_taken"}, {31'b0, pred_taken}, 32'd0);
      checkOutput({tag, " mispredict"}, {31'b0, mispredict}, 32'd0);
      checkOutput({tag, " branch_cnt"}, branch_cnt, 32'd0);
      checkOutput({tag, " miss_cnt"}, miss_cnt, 32'd0);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      lk_valid   = 1'b0;
      lk_pc      = '0;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_taken  = 1'b0;
      upd_pred   = 1'b0;
      stat_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Fresh entry is weakly not-taken
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("first lookup valid", {31'b0, pred_valid}, 32'd1);
      checkOutput("first lookup taken", {31'b0, pred_taken}, 32'd0);

      // Train 0x40 taken twice: 01 -> 10 -> 11
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      checkOutput("idle pred_valid", {31'b0, pred_valid}, 32'd0);
      checkOutput("idle pred_taken holds", {31'b0, pred_taken}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      checkOutput("matched pred no mispredict", {31'b0, mispredict}, 32'd0);
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("trained taken", {31'b0, pred_taken}, 32'd1);

      // Third taken saturates at 11; alias 0x140 shares the entry
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("alias 0x140 taken", {31'b0, pred_taken}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("sat high then one NT", {31'b0, pred_taken}, 32'd1);

      // Walk down to 00, saturate there, then one taken gives 01
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h43, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("sat low then one T", {31'b0, pred_taken}, 32'd0);
      checkOutput("updates so far", branch_cnt, 32'd8);

      // Collision on fresh entry 0x80: update taken and lookup in the same cycle
      applyStimulus(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0);
      checkOutput("collision forward", {31'b0, pred_taken}, 32'd1);
      checkOutput("collision pred_valid", {31'b0, pred_valid}, 32'd1);

      // Perf counters and mispredict pulse
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("clear branch_cnt", branch_cnt, 32'd0);
      checkOutput("clear miss_cnt", miss_cnt, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
      checkOutput("miss pulse", {31'b0, mispredict}, 32'd1);
      checkOutput("miss miss_cnt", miss_cnt, 32'd1);
      checkOutput("miss branch_cnt", branch_cnt, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hC0, 1'b1, 1'b1, 1'b0);
      checkOutput("hit no pulse", {31'b0, mispredict}, 32'd0);
      checkOutput("hit branch_cnt", branch_cnt, 32'd2);
      checkOutput("hit miss_cnt", miss_cnt, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'hC0, 1'b0, 1'b1, 1'b1);
      checkOutput("clr prio branch_cnt", branch_cnt, 32'd0);
      checkOutput("clr prio miss_cnt", miss_cnt, 32'd0);
      checkOutput("clr still pulses", {31'b0, mispredict}, 32'd1);

      // Retrain 0x40 to 11, then reset mid-stream
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      checkOutput("pre-reset pred_taken", {31'b0, pred_taken}, 32'd1);
      checkOutput("pre-reset mispredict", {31'b0, mispredict}, 32'd1);
      checkOutput("pre-reset branch_cnt", branch_cnt, 32'd3);
      checkOutput("pre-reset miss_cnt", miss_cnt, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("post-reset valid", {31'b0, pred_valid}, 32'd1);
      checkOutput("post-reset entry WNT", {31'b0, pred_taken}, 32'd0);
      applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("post-reset 0x80 WNT", {31'b0, pred_taken}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
